// File: rtl/isqrt_formula_n_fsm_if.sv
// rtl/isqrt_formula_n_fsm_if.sv - operand/result and shared-isqrt signal bundle for the formula sequencer
interface isqrt_formula_n_fsm_if #(
    parameter int N_ARGS = 3,
    parameter int ARG_W  = 32,
    parameter int RES_W  = 32
);
    logic                    arg_vld;
    logic                    arg_rdy;
    logic                    mode;
    logic [N_ARGS*ARG_W-1:0] args;
    logic                    res_vld;
    logic [RES_W-1:0]        res;
    logic                    isqrt_x_vld;
    logic [ARG_W-1:0]        isqrt_x;
    logic                    isqrt_y_vld;
    logic [ARG_W/2-1:0]      isqrt_y;

    modport master (
        output arg_vld, mode, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport slave (
        input  arg_vld, mode, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );
endinterface

// File: rtl/isqrt_formula_n_fsm.sv
// rtl/isqrt_formula_n_fsm.sv - SUM / NEST square-root formula sequencer over N_ARGS operands
// Shares one pipelined isqrt core; mode is carried by the state encoding after accept.
module isqrt_formula_n_fsm #(
    parameter int N_ARGS = 3,
    parameter int ARG_W  = 32,
    parameter int RES_W  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    isqrt_formula_n_fsm_if.slave bus
);
    localparam int            CW     = $clog2(N_ARGS + 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [CW-1:0] C_LAST = CW'(N_ARGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM_ISSUE,
        S_SUM_DRAIN,
        S_NEST_WAIT
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [N_ARGS*ARG_W-1:0] r_args, w_args_nxt;
    logic [CW-1:0]           r_ic, w_ic_nxt;
    logic [CW-1:0]           r_rc, w_rc_nxt;
    logic [CW-1:0]           r_k, w_k_nxt;
    logic [RES_W-1:0]        r_res, w_res_nxt;
    logic                    r_res_vld, w_res_vld_nxt;
    logic                    w_arg_rdy;
    logic                    w_x_vld;
    logic [ARG_W-1:0]        w_x;
    logic [RES_W-1:0]        w_y_res;
    logic [ARG_W-1:0]        w_y_arg;

    function automatic logic [ARG_W-1:0] arg_at(input logic [N_ARGS*ARG_W-1:0] a, input int idx);
        return a[idx*ARG_W +: ARG_W];
    endfunction

    assign w_y_res = RES_W'(bus.isqrt_y);
    assign w_y_arg = ARG_W'(bus.isqrt_y);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_args    <= '0;
            r_ic      <= '0;
            r_rc      <= '0;
            r_k       <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_args    <= w_args_nxt;
            r_ic      <= w_ic_nxt;
            r_rc      <= w_rc_nxt;
            r_k       <= w_k_nxt;
            r_res     <= w_res_nxt;
            r_res_vld <= w_res_vld_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_args_nxt    = r_args;
        w_ic_nxt      = r_ic;
        w_rc_nxt      = r_rc;
        w_k_nxt       = r_k;
        w_res_nxt     = r_res;
        w_res_vld_nxt = 1'b0;
        w_arg_rdy     = 1'b0;
        w_x_vld       = 1'b0;
        w_x           = '0;
        case (r_state)
            S_IDLE: begin
                // Gating with rst keeps the combinational issue path quiet while reset is held.
                w_arg_rdy = rst;
                if (bus.arg_vld && rst) begin
                    w_args_nxt = bus.args;
                    w_res_nxt  = '0;
                    w_x_vld    = 1'b1;
                    if (!bus.mode) begin
                        w_x         = arg_at(bus.args, 0);
                        w_ic_nxt    = C_ONE;
                        w_rc_nxt    = '0;
                        w_state_nxt = (N_ARGS == 1) ? S_SUM_DRAIN : S_SUM_ISSUE;
                    end else begin
                        w_x         = arg_at(bus.args, N_ARGS - 1);
                        w_k_nxt     = C_LAST;
                        w_state_nxt = S_NEST_WAIT;
                    end
                end
            end
            S_SUM_ISSUE, S_SUM_DRAIN: begin
                if (r_state == S_SUM_ISSUE) begin
                    w_x_vld  = 1'b1;
                    w_x      = arg_at(r_args, int'(r_ic));
                    w_ic_nxt = r_ic + C_ONE;
                    if (r_ic == C_LAST) begin
                        w_state_nxt = S_SUM_DRAIN;
                    end
                end
                if (bus.isqrt_y_vld) begin
                    w_res_nxt = r_res + w_y_res;
                    w_rc_nxt  = r_rc + C_ONE;
                    if (r_state == S_SUM_DRAIN && r_rc == C_LAST) begin
                        w_state_nxt   = S_IDLE;
                        w_res_vld_nxt = 1'b1;
                    end
                end
            end
            S_NEST_WAIT: begin
                // Each inner result is folded into the next operand and reissued in the same cycle.
                if (bus.isqrt_y_vld) begin
                    if (r_k != '0) begin
                        w_x_vld = 1'b1;
                        w_x     = arg_at(r_args, int'(r_k) - 1) + w_y_arg;
                        w_k_nxt = r_k - C_ONE;
                    end else begin
                        w_res_nxt     = w_y_res;
                        w_res_vld_nxt = 1'b1;
                        w_state_nxt   = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.arg_rdy     = w_arg_rdy;
    assign bus.isqrt_x_vld = w_x_vld;
    assign bus.isqrt_x     = w_x;
    assign bus.res         = r_res;
    assign bus.res_vld     = r_res_vld;
endmodule

// File: tb/tb_isqrt_formula_n_fsm.sv
// tb/tb_isqrt_formula_n_fsm.sv - scoreboard bench for three sequencer configurations and a fixed-latency isqrt model
module tb_isqrt_formula_n_fsm;
    localparam int NI = 3;

    typedef struct {
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    isqrt_formula_n_fsm_if #(.N_ARGS(3), .ARG_W(32), .RES_W(32)) if_a ();
    isqrt_formula_n_fsm_if #(.N_ARGS(3), .ARG_W(32), .RES_W(17)) if_b ();
    isqrt_formula_n_fsm_if #(.N_ARGS(1), .ARG_W(32), .RES_W(32)) if_c ();

    isqrt_formula_n_fsm #(.N_ARGS(3), .ARG_W(32), .RES_W(32)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    isqrt_formula_n_fsm #(.N_ARGS(3), .ARG_W(32), .RES_W(17)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
    isqrt_formula_n_fsm #(.N_ARGS(1), .ARG_W(32), .RES_W(32)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

    logic        av   [NI];
    logic        am   [NI];
    logic [95:0] aa   [NI];
    logic        inj  [NI];
    logic [15:0] inj_d;
    logic [7:0]  pv   [NI] = '{default: '0};
    logic [15:0] pd   [NI][8];
    logic        xv   [NI];
    logic [31:0] xd   [NI];
    logic        rdy  [NI];
    logic        rvv  [NI];
    logic [31:0] rres [NI];

    logic [31:0] exp_x [NI][$];
    exp_t        exp_r [NI][$];
    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    assign if_a.arg_vld = av[0];
    assign if_a.mode    = am[0];
    assign if_a.args    = aa[0];
    assign if_b.arg_vld = av[1];
    assign if_b.mode    = am[1];
    assign if_b.args    = aa[1];
    assign if_c.arg_vld = av[2];
    assign if_c.mode    = am[2];
    assign if_c.args    = aa[2][31:0];

    // isqrt model: latency 4 for the three-operand instances, 1 for the single-operand one
    assign if_a.isqrt_y_vld = pv[0][3] | inj[0];
    assign if_a.isqrt_y     = inj[0] ? inj_d : pd[0][3];
    assign if_b.isqrt_y_vld = pv[1][3] | inj[1];
    assign if_b.isqrt_y     = inj[1] ? inj_d : pd[1][3];
    assign if_c.isqrt_y_vld = pv[2][0] | inj[2];
    assign if_c.isqrt_y     = inj[2] ? inj_d : pd[2][0];

    assign xv[0] = if_a.isqrt_x_vld;  assign xd[0] = if_a.isqrt_x;
    assign xv[1] = if_b.isqrt_x_vld;  assign xd[1] = if_b.isqrt_x;
    assign xv[2] = if_c.isqrt_x_vld;  assign xd[2] = if_c.isqrt_x;
    assign rdy[0] = if_a.arg_rdy;  assign rvv[0] = if_a.res_vld;  assign rres[0] = if_a.res;
    assign rdy[1] = if_b.arg_rdy;  assign rvv[1] = if_b.res_vld;  assign rres[1] = 32'(if_b.res);
    assign rdy[2] = if_c.arg_rdy;  assign rvv[2] = if_c.res_vld;  assign rres[2] = if_c.res;

    function automatic logic [15:0] isqrt_ref(input logic [31:0] x);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r + (longint'(1) << b);
            if (t * t <= longint'(x)) r = t;
        end
        return 16'(r);
    endfunction

    function automatic int n_of(input int i);
        return (i == 2) ? 1 : 3;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 2) ? 1 : 4;
    endfunction

    function automatic logic [31:0] mask_of(input int i);
        return (i == 1) ? 32'h0001_FFFF : 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            pv[i]    <= {pv[i][6:0], xv[i]};
            pd[i][0] <= isqrt_ref(xd[i]);
            for (int j = 1; j < 8; j++) pd[i][j] <= pd[i][j-1];
        end
    end

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ex;
        for (int i = 0; i < NI; i++) begin
            if (xv[i]) begin
                if (exp_x[i].size() == 0) check(1'b0, "extra_issue", xd[i], 32'd0);
                else begin
                    ex = exp_x[i].pop_front();
                    check(xd[i] == ex, "issue_x", xd[i], ex);
                end
            end else if (xd[i] != 32'd0) begin
                check(1'b0, "x_nonzero_when_idle", xd[i], 32'd0);
            end
            if (rvv[i]) begin
                if (exp_r[i].size() == 0) check(1'b0, "extra_res_vld", rres[i], 32'd0);
                else begin
                    e = exp_r[i].pop_front();
                    check(rres[i] == e.r, "res_value", rres[i], e.r);
                    check(cyc == e.cyc, "res_cycle", cyc, e.cyc);
                end
            end else if (exp_r[i].size() != 0 && exp_r[i][0].cyc < cyc) begin
                e = exp_r[i].pop_front();
                check(1'b0, "res_missing", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int i, input logic m, input logic [95:0] a, input logic hold, output int t0);
        int          g;
        int          n;
        logic [31:0] r;
        logic [31:0] x;
        logic [31:0] acc;
        exp_t        e;
        n = n_of(i);
        g = 0;
        av[i] = 1'b1;
        am[i] = m;
        aa[i] = a;
        while (!rdy[i] && g < 400) begin
            tick(1);
            g++;
        end
        if (!rdy[i]) begin
            check(1'b0, "accept_timeout", g, 400);
            av[i] = 1'b0;
            t0 = -1;
            return;
        end
        t0 = cyc;
        if (!m) begin
            acc = 32'd0;
            for (int k = 0; k < n; k++) begin
                x = a[k*32 +: 32];
                exp_x[i].push_back(x);
                acc = acc + 32'(isqrt_ref(x));
            end
            e.r   = acc & mask_of(i);
            e.cyc = t0 + n + lat_of(i);
        end else begin
            x = a[(n-1)*32 +: 32];
            exp_x[i].push_back(x);
            r = 32'(isqrt_ref(x));
            for (int k = n - 1; k > 0; k--) begin
                x = a[(k-1)*32 +: 32] + r;
                exp_x[i].push_back(x);
                r = 32'(isqrt_ref(x));
            end
            e.r   = r & mask_of(i);
            e.cyc = t0 + n * lat_of(i) + 1;
        end
        exp_r[i].push_back(e);
        tick(1);
        if (!hold) av[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int g;
        g = 0;
        while (exp_r[i].size() != 0 && g < 300) begin
            tick(1);
            g++;
        end
        if (exp_r[i].size() != 0) begin
            check(1'b0, "result_timeout", exp_r[i].size(), 0);
            exp_r[i].delete();
            exp_x[i].delete();
        end
        tick(1);
    endtask

    task automatic mid_reset();
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            exp_x[i].delete();
            exp_r[i].delete();
        end
        #1;
        check(xv[0] == 1'b0, "mid_rst_x_vld", xv[0], 0);
        check(xd[0] == 32'd0, "mid_rst_x", xd[0], 0);
        check(rres[0] == 32'd0, "mid_rst_res", rres[0], 0);
        check(rvv[0] == 1'b0, "mid_rst_res_vld", rvv[0], 0);
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, actual cycle %0d required finish", cyc);
        $fatal(1);
    end

    initial begin
        int          t1;
        int          t2;
        logic        hold;
        logic [95:0] basic;
        logic [95:0] ones;
        logic [95:0] ra;
        for (int i = 0; i < NI; i++) begin
            av[i]  = 1'b0;
            am[i]  = 1'b0;
            aa[i]  = '0;
            inj[i] = 1'b0;
        end
        inj_d = 16'd9;
        basic = {32'd1000, 32'd81, 32'd16};
        ones  = '1;
        aa[0] = basic;
        av[0] = 1'b1;
        tick(2);
        for (int i = 0; i < NI; i++) begin
            check(rres[i] == 32'd0, "reset_res", rres[i], 0);
            check(rvv[i] == 1'b0, "reset_res_vld", rvv[i], 0);
            check(xv[i] == 1'b0, "reset_x_vld", xv[i], 0);
            check(xd[i] == 32'd0, "reset_x", xd[i], 0);
        end
        av[0] = 1'b0;
        rst   = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check(rdy[i] == 1'b1, "reset_arg_rdy", rdy[i], 1);
        tick(1);

        send(0, 1'b0, basic, 1'b0, t1);
        wait_done(0);
        check(rres[0] == 32'd44, "sum_basic", rres[0], 44);
        send(0, 1'b1, basic, 1'b0, t1);
        wait_done(0);
        check(rres[0] == 32'd5, "nest_basic", rres[0], 5);

        send(1, 1'b0, ones, 1'b0, t1);
        wait_done(1);
        check(rres[1] == 32'd65533, "wrap_sum", rres[1], 65533);
        send(1, 1'b1, ones, 1'b0, t1);
        wait_done(1);
        check(rres[1] == 32'd15, "wrap_nest", rres[1], 15);

        send(0, 1'b0, basic, 1'b1, t1);
        send(0, 1'b1, basic, 1'b0, t2);
        check(t2 == t1 + 7, "b2b_accept_cycle", t2, t1 + 7);
        wait_done(0);
        check(rres[0] == 32'd5, "b2b_final", rres[0], 5);

        send(0, 1'b0, basic, 1'b0, t1);
        tick(2);
        mid_reset();
        tick(8);
        check(rres[0] == 32'd0, "sum_rst_stray_res", rres[0], 0);
        check(rdy[0] == 1'b1, "sum_rst_rdy", rdy[0], 1);

        send(0, 1'b1, basic, 1'b0, t1);
        tick(3);
        check(xv[0] == 1'b1, "nest_issue_live", xv[0], 1);
        mid_reset();
        tick(1);
        inj[0] = 1'b1;
        tick(1);
        inj[0] = 1'b0;
        tick(6);
        check(rres[0] == 32'd0, "nest_rst_stray_res", rres[0], 0);
        check(rvv[0] == 1'b0, "nest_rst_stray_vld", rvv[0], 0);

        send(2, 1'b0, 96'd49, 1'b0, t1);
        wait_done(2);
        check(rres[2] == 32'd7, "n1_sum", rres[2], 7);
        send(2, 1'b1, 96'd49, 1'b0, t1);
        wait_done(2);
        check(rres[2] == 32'd7, "n1_nest", rres[2], 7);
        inj[2] = 1'b1;
        tick(3);
        inj[2] = 1'b0;
        tick(2);
        check(rres[2] == 32'd7, "n1_idle_y_ignored", rres[2], 7);
        check(rvv[2] == 1'b0, "n1_idle_no_vld", rvv[2], 0);

        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 15; k++) begin
                ra = {$urandom, $urandom, $urandom};
                if ($urandom_range(0, 2) == 0) ra = ra & {3{32'h0000_FFFF}};
                hold = (k < 14) && ($urandom_range(0, 2) == 0);
                send(i, 1'($urandom_range(0, 1)), ra, hold, t1);
                if (!hold) begin
                    wait_done(i);
                    tick($urandom_range(0, 3));
                end
            end
            wait_done(i);
        end

        tick(10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
